sub_skid: RTL and testbench

- Type-parameterised valid/ready register slice (2-entry skid buffer) directly downstream of the `sub` inverter stage.
- Registers `sub`'s combinational `out` at full throughput, breaking timing between the inverter and the consumer.
- Counts words delivered downstream.
- Carries the same TYPE_t as `sub`, so the two instantiate back to back with one type override.

---
 rtl/sub_skid.sv | 113 +++++++++++
 tb/tb_sub_skid.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_skid.sv
// ============================================================================
//  Module   : sub_skid
//  Purpose  : Two-entry valid/ready register slice (skid buffer) placed
//             directly after the `sub` inverter stage. Registers the payload
//             at full throughput and counts words delivered downstream.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_skid #(
    parameter type TYPE_t = logic,
    parameter int  CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  TYPE_t            in,
    output logic             out_valid,
    input  logic             out_ready,
    output TYPE_t            out,
    output logic [CNT_W-1:0] xfer_count
);

    // EMPTY: nothing held; ONE: main register valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    TYPE_t             main_q,  main_d;
    TYPE_t             skid_q,  skid_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              in_fire;
    logic              out_fire;

    // Handshake outputs are pure decodes of the registered state, so neither
    // in_valid nor out_ready has a combinational path to any output.
    assign in_ready   = (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign out        = main_q;
    assign xfer_count = cnt_q;

    assign in_fire  = in_valid  & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state, storage-update and counter logic
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (out_fire) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    // Full-throughput case: replace the departing word
                    main_d = in;
                end else if (in_fire) begin
                    // Consumer stalled: park the new word behind main
                    skid_d  = in;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    // main keeps its stale value; out_valid drops instead
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no write can occur
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and storage registers; reset discards any held words
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sub_skid.sv
// ============================================================================
//  Module   : tb_sub_skid
//  Purpose  : Self-checking bench for sub_skid with an 8-bit payload fed
//             through a behavioural model of the `sub` inverter stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sub_skid;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_l = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [7:0]       sub_in = 8'hFF;
    logic [7:0]       slice_in;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       dout;
    logic [CNT_W-1:0] xfer_count;

    // Upstream `sub` stage: bitwise inverter feeding the slice
    assign slice_in = ~sub_in;

    sub_skid #(
        .TYPE_t (logic [7:0]),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (slice_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (dout),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a FIFO of at most two words, the last word shown on
    // the output, and a delivered-word count.
    logic [7:0]       mq[$];
    logic [7:0]       m_last;
    logic [CNT_W-1:0] m_cnt;

    typedef struct {
        logic             iv;
        logic [7:0]       d;
        logic             ordy;
        logic             ev;
        logic             er;
        logic [7:0]       eo;
        logic [CNT_W-1:0] ec;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = 8'h00;
        m_cnt  = '0;
    endtask

    task automatic chk_model();
        logic [7:0] exp_out;
        exp_out = m_last;
        if (mq.size() > 0) exp_out = mq[0];
        chk("model_out_valid",  {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("model_in_ready",   {31'd0, in_ready},  {31'd0, mq.size() < 2});
        chk("model_out",        {24'd0, dout},      {24'd0, exp_out});
        chk("model_xfer_count", 32'(xfer_count),    32'(m_cnt));
    endtask

    // One clock: check current outputs against the model, drive inputs,
    // advance the model at the edge, and return at the following negedge.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
        logic m_in_fire, m_out_fire;
        chk_model();
        in_valid  = iv;
        sub_in    = ~d;
        out_ready = ordy;
        m_in_fire  = iv && (mq.size() < 2);
        m_out_fire = ordy && (mq.size() > 0);
        @(posedge clk);
        if (m_out_fire) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (m_in_fire) mq.push_back(d);
        if (mq.size() > 0) m_last = mq[0];
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_l   = 1'b0;
        @(negedge clk);
        reset_l   = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();

        // ---------------- Reset / idle ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out",       {24'd0, dout},      32'h00);
        chk("rst_count",     32'(xfer_count),    32'd0);
        reset_l = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_in_ready",  {31'd0, in_ready},  32'd1);
        chk("idle_out",       {24'd0, dout},      32'h00);
        chk("idle_count",     32'(xfer_count),    32'd0);

        // ---------------- Streaming 01..08 ----------------
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(i + 1), 1'b1);
            chk("stream_out",   {24'd0, dout},      32'(i + 1));
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_ready", {31'd0, in_ready},  32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1);
        chk("stream_count", 32'(xfer_count), 32'd8);
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // ---------------- Backpressure fill (table) ----------------
        do_reset();
        vecs[0] = '{iv:1'b1, d:8'hA5, ordy:1'b0, ev:1'b1, er:1'b1, eo:8'hA5, ec:4'd0};
        vecs[1] = '{iv:1'b1, d:8'h5A, ordy:1'b0, ev:1'b1, er:1'b0, eo:8'hA5, ec:4'd0};
        vecs[2] = '{iv:1'b1, d:8'hFF, ordy:1'b0, ev:1'b1, er:1'b0, eo:8'hA5, ec:4'd0};
        vecs[3] = '{iv:1'b1, d:8'hFF, ordy:1'b1, ev:1'b1, er:1'b1, eo:8'h5A, ec:4'd1};
        vecs[4] = '{iv:1'b0, d:8'h00, ordy:1'b1, ev:1'b0, er:1'b1, eo:8'h5A, ec:4'd2};
        vecs[5] = '{iv:1'b0, d:8'h00, ordy:1'b0, ev:1'b0, er:1'b1, eo:8'h5A, ec:4'd2};
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk($sformatf("bp%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("bp%0d_ready", i), {31'd0, in_ready},  {31'd0, vecs[i].er});
            chk($sformatf("bp%0d_out", i),   {24'd0, dout},      {24'd0, vecs[i].eo});
            chk($sformatf("bp%0d_count", i), 32'(xfer_count),    32'(vecs[i].ec));
        end

        // ---------------- Stall stability ----------------
        cycle(1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'(i % 2), 8'($urandom), 1'b0);
            chk("stall_out",   {24'd0, dout},      32'h11);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("stall_drained", {31'd0, out_valid}, 32'd0);

        // ---------------- Counter wrap ----------------
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_count", 32'(xfer_count), 32'd1);

        // ---------------- Async reset while FULL ----------------
        do_reset();
        cycle(1'b1, 8'h21, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        chk("full_before_rst", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2 reset_l = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("arst_out",       {24'd0, dout},      32'h00);
        chk("arst_count",     32'(xfer_count),    32'd0);
        model_reset();
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        cycle(1'b1, 8'h77, 1'b1);
        chk("arst_first_word", {24'd0, dout},      32'h77);
        chk("arst_first_vld",  {31'd0, out_valid}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);

        // ---------------- Randomised traffic ----------------
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        chk_model();

        // ---------------- Chained with sub ----------------
        do_reset();
        in_valid  = 1'b1;
        sub_in    = 8'h3C;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        chk("chain_out",   {24'd0, dout},      32'hC3);
        chk("chain_valid", {31'd0, out_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
